// File: rtl/legv8_pkg.sv
// legv8_pkg: shared LEGv8 ALU operation codes, opcode constants and issue-buffer types
package legv8_pkg;
    localparam logic [3:0] OP_AND   = 4'd0;
    localparam logic [3:0] OP_ORR   = 4'd1;
    localparam logic [3:0] OP_ADD   = 4'd2;
    localparam logic [3:0] OP_SUB   = 4'd6;
    localparam logic [3:0] OP_PASSB = 4'd7;
    localparam logic [3:0] OP_NOR   = 4'd12;
    localparam logic [1:0] ALUOP_MEM = 2'b00;
    localparam logic [1:0] ALUOP_CBZ = 2'b01;
    localparam logic [1:0] ALUOP_R   = 2'b10;
    localparam logic [1:0] ALUOP_I   = 2'b11;
    localparam logic [10:0] OPC_ADD = 11'b10001011000;
    localparam logic [10:0] OPC_SUB = 11'b11001011000;
    localparam logic [10:0] OPC_AND = 11'b10001010000;
    localparam logic [10:0] OPC_ORR = 11'b10101010000;
    localparam logic [9:0] OPC_ADDI = 10'b1001000100;
    localparam logic [9:0] OPC_SUBI = 10'b1101000100;
    typedef struct packed {
        logic [3:0]  op;
        logic [63:0] a;
        logic [63:0] b;
    } entry_t;
    typedef enum logic [1:0] {EMPTY, ONE, FULL} buf_state_t;
endpackage

// File: rtl/alu_control.sv
// alu_control: combinational LEGv8 ALU control decode with illegal-op detection
module alu_control
    import legv8_pkg::*;
(
    input  logic [1:0]  alu_op,
    input  logic [10:0] opcode,
    output logic [3:0]  op,
    output logic        illegal
);
    always_comb begin
        op = OP_ADD;
        illegal = 1'b0;
        case (alu_op)
            ALUOP_MEM: op = OP_ADD;
            ALUOP_CBZ: op = OP_PASSB;
            ALUOP_R: case (opcode)
                OPC_ADD: op = OP_ADD;
                OPC_SUB: op = OP_SUB;
                OPC_AND: op = OP_AND;
                OPC_ORR: op = OP_ORR;
                default: illegal = 1'b1;
            endcase
            default: case (opcode[10:1])
                OPC_ADDI: op = OP_ADD;
                OPC_SUBI: op = OP_SUB;
                default:  illegal = 1'b1;
            endcase
        endcase
    end
endmodule

// File: rtl/alu_issue_stage.sv
// alu_issue_stage: decodes ALU ops and issues them through a 2-entry skid buffer;
// illegal ops are dropped and counted
module alu_issue_stage
    import legv8_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       ALUOp,
    input  logic [10:0]      Opcode,
    input  logic             ALUSrc,
    input  logic [63:0]      RegData1,
    input  logic [63:0]      RegData2,
    input  logic [63:0]      SignExtImm,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       ALU_Operation,
    output logic [63:0]      A,
    output logic [63:0]      B,
    output logic             illegal,
    output logic [CNT_W-1:0] illegal_cnt
);
    buf_state_t state, state_nx;
    entry_t e0, e1, in_e;
    logic [3:0] dec_op;
    logic dec_ill, acc, push, pop;

    alu_control u_ctl (.alu_op(ALUOp), .opcode(Opcode), .op(dec_op), .illegal(dec_ill));

    assign in_e = '{op: dec_op, a: RegData1, b: ALUSrc ? SignExtImm : RegData2};
    assign in_ready = state != FULL;
    assign out_valid = state != EMPTY;
    assign acc = in_valid && in_ready && !flush;
    assign push = acc && !dec_ill;
    assign pop = out_valid && out_ready;
    assign ALU_Operation = e0.op;
    assign A = e0.a;
    assign B = e0.b;

    // push cannot occur in FULL because in_ready is low there
    always_comb begin
        state_nx = state;
        if (flush) state_nx = EMPTY;
        else if (push && !pop) state_nx = state == EMPTY ? ONE : FULL;
        else if (pop && !push) state_nx = state == FULL ? ONE : EMPTY;
    end

    // e0 is always the oldest entry and drives the ALU; e1 is the skid slot
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= EMPTY;
            e0 <= '0;
            e1 <= '0;
            illegal <= 1'b0;
            illegal_cnt <= '0;
        end else begin
            state <= state_nx;
            if (!flush) begin
                if (push && (state == EMPTY || pop)) e0 <= in_e;
                else if (push) e1 <= in_e;
                else if (pop && state == FULL) e0 <= e1;
            end
            illegal <= acc && dec_ill;
            if (acc && dec_ill && illegal_cnt != '1) illegal_cnt <= illegal_cnt + CNT_W'(1);
        end
    end
endmodule
